// File: rtl/boid_pkg.sv
// Shared types and constants for the boid per-frame integration engine.
// Positions and velocities are signed Q16.16 words.
package boid_pkg;

    typedef logic signed [31:0] fix32_t;

    localparam int         FRAC_BITS = 16;
    localparam logic [6:0] WB_ALL    = 7'h7F;

    localparam int     LEFT_MARGIN_DEF   = 100;
    localparam int     RIGHT_MARGIN_DEF  = 540;
    localparam int     TOP_MARGIN_DEF    = 100;
    localparam int     BOTTOM_MARGIN_DEF = 380;
    localparam fix32_t TURN_DEF          = 32'sd13107;
    localparam fix32_t MAX_SPEED_DEF     = 32'sd393216;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_VEL,
        S_LIMIT,
        S_WRITE,
        S_DONE
    } state_t;

endpackage

// File: rtl/boid_update_engine_if.sv
// Handshake plus boid-memory read/write bus of the update engine.
// master = engine side, slave = memory / controller side.
interface boid_update_engine_if #(
    parameter int IDX_W = 2
);
    import boid_pkg::*;

    logic             start;
    logic             busy;
    logic             done;
    logic [IDX_W-1:0] which_boid;
    logic [6:0]       wb_en;

    fix32_t x_out_32, y_out_32, vx_out_32, vy_out_32, vx_acc_out, vy_acc_out;
    fix32_t x_in_32, y_in_32, vx_in_32, vy_in_32, vx_acc_in, vy_acc_in;

    modport master (
        input  start,
        input  x_out_32, y_out_32, vx_out_32, vy_out_32, vx_acc_out, vy_acc_out,
        output busy, done, which_boid, wb_en,
        output x_in_32, y_in_32, vx_in_32, vy_in_32, vx_acc_in, vy_acc_in
    );

    modport slave (
        output start,
        output x_out_32, y_out_32, vx_out_32, vy_out_32, vx_acc_out, vy_acc_out,
        input  busy, done, which_boid, wb_en,
        input  x_in_32, y_in_32, vx_in_32, vy_in_32, vx_acc_in, vy_acc_in
    );

endinterface

// File: rtl/boid_axis_update.sv
// One axis of the boid integration: add acceleration, screen-margin turn,
// per-axis speed clamp and position advance. Purely combinational.
module boid_axis_update
    import boid_pkg::*;
#(
    parameter fix32_t TURN      = TURN_DEF,
    parameter fix32_t MAX_SPEED = MAX_SPEED_DEF
) (
    input  fix32_t pos_i,
    input  fix32_t vel_i,
    input  fix32_t acc_i,
    input  fix32_t lo_margin_i,
    input  fix32_t hi_margin_i,
    output fix32_t vel_o,
    output fix32_t pos_o
);

    fix32_t pixel;
    fix32_t vel_turn;

    always_comb begin
        // NOTE: every variable gets a default before any condition, so no path infers a latch.
        pixel    = pos_i >>> FRAC_BITS;
        vel_turn = vel_i + acc_i;

        if (pixel < lo_margin_i) vel_turn = vel_turn + TURN;
        if (pixel > hi_margin_i) vel_turn = vel_turn - TURN;

        vel_o = vel_turn;
        if (vel_turn > MAX_SPEED)       vel_o = MAX_SPEED;
        else if (vel_turn < -MAX_SPEED) vel_o = -MAX_SPEED;

        pos_o = pos_i + vel_o;
    end

endmodule

// File: rtl/boid_update_engine.sv
// Per-frame boid integrator: walks every boid, updates velocity/position and
// clears the accumulators. `reset` is asynchronous and active-low.
module boid_update_engine
    import boid_pkg::*;
#(
    parameter int     num_boids     = 2,
    parameter int     LEFT_MARGIN   = LEFT_MARGIN_DEF,
    parameter int     RIGHT_MARGIN  = RIGHT_MARGIN_DEF,
    parameter int     TOP_MARGIN    = TOP_MARGIN_DEF,
    parameter int     BOTTOM_MARGIN = BOTTOM_MARGIN_DEF,
    parameter fix32_t TURN          = TURN_DEF,
    parameter fix32_t MAX_SPEED     = MAX_SPEED_DEF
) (
    input logic                  clk,
    input logic                  reset,
    boid_update_engine_if.master bus
);

    localparam int IDX_W = $clog2(num_boids) + 1;

    state_t           state_q;
    logic [IDX_W-1:0] index_q;
    logic [IDX_W-1:0] which_q;
    logic             busy_q;
    logic             done_q;
    logic [6:0]       wb_en_q;

    fix32_t x_q, y_q, vx_q, vy_q, vx_acc_q, vy_acc_q;
    fix32_t x_nxt_q, y_nxt_q, vx_nxt_q, vy_nxt_q;
    fix32_t x_wr_q, y_wr_q, vx_wr_q, vy_wr_q;
    fix32_t x_new, y_new, vx_new, vy_new;

    boid_axis_update #(.TURN(TURN), .MAX_SPEED(MAX_SPEED)) u_axis_x (
        .pos_i       (x_q),
        .vel_i       (vx_q),
        .acc_i       (vx_acc_q),
        .lo_margin_i (fix32_t'(LEFT_MARGIN)),
        .hi_margin_i (fix32_t'(RIGHT_MARGIN)),
        .vel_o       (vx_new),
        .pos_o       (x_new)
    );

    boid_axis_update #(.TURN(TURN), .MAX_SPEED(MAX_SPEED)) u_axis_y (
        .pos_i       (y_q),
        .vel_i       (vy_q),
        .acc_i       (vy_acc_q),
        .lo_margin_i (fix32_t'(TOP_MARGIN)),
        .hi_margin_i (fix32_t'(BOTTOM_MARGIN)),
        .vel_o       (vy_new),
        .pos_o       (y_new)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            index_q  <= '0;
            which_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            wb_en_q  <= '0;
            x_q      <= '0;  y_q      <= '0;
            vx_q     <= '0;  vy_q     <= '0;
            vx_acc_q <= '0;  vy_acc_q <= '0;
            x_nxt_q  <= '0;  y_nxt_q  <= '0;
            vx_nxt_q <= '0;  vy_nxt_q <= '0;
            x_wr_q   <= '0;  y_wr_q   <= '0;
            vx_wr_q  <= '0;  vy_wr_q  <= '0;
        end else begin
            // NOTE: non-blocking only; each stage sees the other registers as they were before this edge.
            wb_en_q <= '0;
            done_q  <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        busy_q  <= 1'b1;
                        which_q <= index_q;
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    x_q      <= bus.x_out_32;
                    y_q      <= bus.y_out_32;
                    vx_q     <= bus.vx_out_32;
                    vy_q     <= bus.vy_out_32;
                    vx_acc_q <= bus.vx_acc_out;
                    vy_acc_q <= bus.vy_acc_out;
                    state_q  <= S_VEL;
                end
                S_VEL: begin
                    vx_nxt_q <= vx_new;
                    vy_nxt_q <= vy_new;
                    x_nxt_q  <= x_new;
                    y_nxt_q  <= y_new;
                    state_q  <= S_LIMIT;
                end
                S_LIMIT: begin
                    x_wr_q  <= x_nxt_q;
                    y_wr_q  <= y_nxt_q;
                    vx_wr_q <= vx_nxt_q;
                    vy_wr_q <= vy_nxt_q;
                    wb_en_q <= WB_ALL;
                    state_q <= S_WRITE;
                end
                S_WRITE: begin
                    if (index_q == IDX_W'(num_boids - 1)) begin
                        index_q <= '0;
                        which_q <= '0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        index_q <= index_q + 1'b1;
                        which_q <= index_q + 1'b1;
                        state_q <= S_LOAD;
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.which_boid = which_q;
    assign bus.wb_en      = wb_en_q;
    assign bus.x_in_32    = x_wr_q;
    assign bus.y_in_32    = y_wr_q;
    assign bus.vx_in_32   = vx_wr_q;
    assign bus.vy_in_32   = vy_wr_q;
    assign bus.vx_acc_in  = '0;
    assign bus.vy_acc_in  = '0;

endmodule

// File: tb/tb_boid_update_engine.sv
// Self-checking bench for boid_update_engine: behavioural boid memory,
// hand-computed vectors, randomized passes against a real-valued reference model.
module tb_boid_update_engine;
    import boid_pkg::*;

    localparam int NB     = 2;
    localparam int IDX_W  = $clog2(NB) + 1;
    localparam int DEPTH  = 1 << IDX_W;
    localparam int TURN_I = 13107;
    localparam int MAXS_I = 6 * 65536;
    localparam int LEFT   = 100;
    localparam int RIGHT  = 540;
    localparam int TOP    = 100;
    localparam int BOTTOM = 380;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    boid_update_engine_if #(.IDX_W(IDX_W)) bus();

    boid_update_engine #(.num_boids(NB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Field order: x, y, vx, vy, vx_acc, vy_acc (matches wb_en bits 1..6)
    fix32_t mem [DEPTH][6];
    fix32_t wdata [6];
    int     exp_mem [DEPTH][6];

    logic   pre_en;
    int     pre_idx;
    fix32_t pre_val [6];

    assign bus.x_out_32   = mem[bus.which_boid][0];
    assign bus.y_out_32   = mem[bus.which_boid][1];
    assign bus.vx_out_32  = mem[bus.which_boid][2];
    assign bus.vy_out_32  = mem[bus.which_boid][3];
    assign bus.vx_acc_out = mem[bus.which_boid][4];
    assign bus.vy_acc_out = mem[bus.which_boid][5];
    assign wdata[0] = bus.x_in_32;
    assign wdata[1] = bus.y_in_32;
    assign wdata[2] = bus.vx_in_32;
    assign wdata[3] = bus.vy_in_32;
    assign wdata[4] = bus.vx_acc_in;
    assign wdata[5] = bus.vy_acc_in;

    always @(posedge clk) begin
        if (pre_en) begin
            for (int f = 0; f < 6; f++) mem[pre_idx][f] <= pre_val[f];
        end else if (bus.wb_en[0]) begin
            for (int f = 0; f < 6; f++)
                if (bus.wb_en[f+1]) mem[bus.which_boid][f] <= wdata[f];
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic preload(input int b, input int x, input int y, input int vx,
                           input int vy, input int ax, input int ay);
        pre_idx    = b;
        pre_val[0] = x;   pre_val[1] = y;
        pre_val[2] = vx;  pre_val[3] = vy;
        pre_val[4] = ax;  pre_val[5] = ay;
        for (int f = 0; f < 6; f++) exp_mem[b][f] = pre_val[f];
        pre_en = 1'b1;
        @(posedge clk);
        #1 pre_en = 1'b0;
    endtask

    function automatic int rnd_pos();
        return int'($urandom_range(0, 750 * 65536)) - 50 * 65536;
    endfunction

    function automatic int rnd_sym(input int mag);
        return int'($urandom_range(0, 2 * mag)) - mag;
    endfunction

    task automatic rand_boid(input int b);
        preload(b, rnd_pos(), rnd_pos(), rnd_sym(10 * 65536), rnd_sym(10 * 65536),
                rnd_sym(4 * 65536), rnd_sym(4 * 65536));
    endtask

    // Reference: pixel tests done on the real-valued position, which for integer
    // margins is equivalent to comparing the floored pixel strictly.
    task automatic apply_model(input int b);
        for (int a = 0; a < 2; a++) begin
            int  pos = exp_mem[b][a];
            int  v   = exp_mem[b][2+a] + exp_mem[b][4+a];
            int  lo  = (a == 0) ? LEFT : TOP;
            int  hi  = (a == 0) ? RIGHT : BOTTOM;
            real pix = real'(pos) / 65536.0;
            if (pix < real'(lo))      v = v + TURN_I;
            if (pix >= real'(hi + 1)) v = v - TURN_I;
            if (v > MAXS_I)  v = MAXS_I;
            if (v < -MAXS_I) v = -MAXS_I;
            exp_mem[b][a]   = pos + v;
            exp_mem[b][2+a] = v;
        end
        exp_mem[b][4] = 0;
        exp_mem[b][5] = 0;
    endtask

    task automatic compare_mem(input string tag);
        for (int b = 0; b < NB; b++)
            for (int f = 0; f < 6; f++)
                check($sformatf("%s boid%0d field%0d", tag, b, f), mem[b][f], exp_mem[b][f]);
    endtask

    // Caller is positioned at a negedge; returns at the negedge inside the DONE cycle.
    task automatic run_pass(input string tag, input int inject_cyc, input bit want_timing);
        int cyc    = 0;
        int writes = 0;
        int bad    = 0;
        bit seen   = 1'b0;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        while (!seen && cyc < 40) begin
            @(negedge clk);
            cyc++;
            bus.start = (cyc == inject_cyc);
            if (cyc == 1) check({tag, " busy_after_accept"}, bus.busy, 1);
            if (bus.wb_en == WB_ALL) begin
                writes++;
                if ((cyc % 4) != 0) bad++;
            end else if (bus.wb_en != 7'h00) begin
                bad++;
            end
            if (bus.done) seen = 1'b1;
        end
        bus.start = 1'b0;
        check({tag, " done_seen"}, seen, 1);
        check({tag, " write_pulses"}, writes, NB);
        check({tag, " wb_en_shape_errors"}, bad, 0);
        if (want_timing) begin
            check({tag, " done_latency"}, cyc, 9);
            check({tag, " busy_in_done"}, bus.busy, 1);
        end
    endtask

    typedef struct {
        int x, y, vx, vy, ax, ay;
        int ex, ey, evx, evy;
    } vec_t;

    vec_t vecs [8];

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        vecs[0] = '{120*65536, 200*65536, 5*65536, 0, 1*65536, 0,
                    126*65536, 200*65536, 6*65536, 0};
        vecs[1] = '{200*65536, 200*65536, 5*65536, -4*65536, 5*65536, -10*65536,
                    206*65536, 194*65536, 6*65536, -6*65536};
        vecs[2] = '{50*65536, 200*65536, 0, 0, 0, 0,
                    50*65536 + 13107, 200*65536, 13107, 0};
        vecs[3] = '{541*65536, 200*65536, 0, 0, 0, 0,
                    541*65536 - 13107, 200*65536, -13107, 0};
        vecs[4] = '{100*65536, 100*65536, 0, 0, 0, 0,
                    100*65536, 100*65536, 0, 0};
        vecs[5] = '{540*65536, 50*65536, 0, 0, 0, 0,
                    540*65536, 50*65536 + 13107, 0, 13107};
        vecs[6] = '{100*65536 - 1, 381*65536, 0, 0, 0, 0,
                    100*65536 - 1 + 13107, 381*65536 - 13107, 13107, -13107};
        vecs[7] = '{300*65536, 380*65536, -2*65536, 1*65536, 0, 0,
                    298*65536, 381*65536, -2*65536, 1*65536};

        bus.start = 1'b0;
        pre_en    = 1'b0;
        pre_idx   = 0;
        for (int f = 0; f < 6; f++) pre_val[f] = '0;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset busy",       bus.busy, 0);
        check("reset done",       bus.done, 0);
        check("reset wb_en",      bus.wb_en, 0);
        check("reset which_boid", bus.which_boid, 0);
        check("reset x_in_32",    bus.x_in_32, 0);
        check("reset vx_in_32",   bus.vx_in_32, 0);
        reset = 1'b1;

        // Hand-computed vectors on boid0, random boid1 against the model
        for (int i = 0; i < 8; i++) begin
            preload(0, vecs[i].x, vecs[i].y, vecs[i].vx, vecs[i].vy, vecs[i].ax, vecs[i].ay);
            rand_boid(1);
            @(negedge clk);
            run_pass($sformatf("vec%0d", i), 0, i == 0);
            apply_model(1);
            exp_mem[0][0] = vecs[i].ex;
            exp_mem[0][1] = vecs[i].ey;
            exp_mem[0][2] = vecs[i].evx;
            exp_mem[0][3] = vecs[i].evy;
            exp_mem[0][4] = 0;
            exp_mem[0][5] = 0;
            compare_mem($sformatf("vec%0d", i));
            @(negedge clk);
            check($sformatf("vec%0d done_one_cycle", i), bus.done, 0);
            check($sformatf("vec%0d busy_dropped", i), bus.busy, 0);
        end

        // Randomized passes
        for (int r = 0; r < 6; r++) begin
            rand_boid(0);
            rand_boid(1);
            @(negedge clk);
            run_pass($sformatf("rnd%0d", r), 0, 1'b0);
            apply_model(0);
            apply_model(1);
            compare_mem($sformatf("rnd%0d", r));
            @(negedge clk);
        end

        // Start pulsed while busy must not launch a second pass
        begin
            int extra = 0;
            rand_boid(0);
            rand_boid(1);
            @(negedge clk);
            run_pass("busy_start", 3, 1'b0);
            apply_model(0);
            apply_model(1);
            repeat (12) begin
                @(negedge clk);
                if (bus.done || bus.busy) extra++;
            end
            check("busy_start no_second_pass", extra, 0);
            compare_mem("busy_start");
        end

        // Start during the DONE cycle is ignored
        begin
            int extra = 0;
            rand_boid(0);
            rand_boid(1);
            @(negedge clk);
            run_pass("done_start", 0, 1'b0);
            apply_model(0);
            apply_model(1);
            bus.start = 1'b1;
            @(negedge clk);
            bus.start = 1'b0;
            repeat (8) begin
                if (bus.busy || bus.wb_en != 7'h00) extra++;
                @(negedge clk);
            end
            check("done_start ignored", extra, 0);
            compare_mem("done_start");
        end

        // Start in the IDLE cycle right after DONE begins a new pass
        rand_boid(0);
        rand_boid(1);
        @(negedge clk);
        run_pass("b2b first", 0, 1'b0);
        apply_model(0);
        apply_model(1);
        @(negedge clk);
        check("b2b idle_gap busy", bus.busy, 0);
        run_pass("b2b second", 0, 1'b1);
        apply_model(0);
        apply_model(1);
        compare_mem("b2b");
        @(negedge clk);

        // Reset while boid1 is in VEL: boid0 already written, boid1 untouched
        rand_boid(0);
        rand_boid(1);
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (6) @(negedge clk);
        reset = 1'b0;
        #1;
        check("midreset busy",       bus.busy, 0);
        check("midreset wb_en",      bus.wb_en, 0);
        check("midreset done",       bus.done, 0);
        check("midreset which_boid", bus.which_boid, 0);
        check("midreset x_in_32",    bus.x_in_32, 0);
        apply_model(0);
        @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        check("midreset stays idle", bus.busy, 0);
        compare_mem("midreset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/boid_update_engine.md
Name: boid_update_engine

Overview:
- Per-frame integration stage directly upstream of the boid register memory.
- On a start pulse, walks boids 0..num_boids-1 in order. For each boid it reads state over the memory's combinational read port, then:
  - adds accumulated acceleration to velocity;
  - applies a screen-margin turn;
  - clamps velocity per axis;
  - advances position;
  - writes everything back and zeroes both accumulators.
- The accumulation stage fills vx_acc/vy_acc between frames; this block consumes and clears them.

Parameters:
- num_boids, 2, boid count; sets the index width.
- LEFT_MARGIN, 100, integer pixel x below which +TURN is added to vx.
- RIGHT_MARGIN, 540, integer pixel x above which -TURN is added to vx.
- TOP_MARGIN, 100, integer pixel y below which +TURN is added to vy.
- BOTTOM_MARGIN, 380, integer pixel y above which -TURN is added to vy.
- TURN, 13107, Q16.16 turn step (~0.2).
- MAX_SPEED, 6<<16, Q16.16 per-axis velocity magnitude limit.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to update all boids; honoured only in IDLE
- busy  out  1  high from the cycle after start is accepted until DONE exits
- done  out  1  one-cycle pulse when the last boid's write completes
- which_boid  out  $clog2(num_boids)+1  memory index, read and write
- wb_en  out  7  bit0 global write enable; bits1..6 select x, y, vx, vy, vx_acc, vy_acc
- x_out_32, y_out_32, vx_out_32, vy_out_32, vx_acc_out, vy_acc_out  in  32 each  sign-extended Q16.16 memory read data
- x_in_32, y_in_32, vx_in_32, vy_in_32, vx_acc_in, vy_acc_in  out  32 each  Q16.16 write data; the memory truncates

Behaviour:
- Reset (async, reset==0):
  - state=IDLE; index=0; all working registers 0.
  - busy=0, done=0, wb_en=0, which_boid=0, all write data 0.
- FSM: IDLE -> LOAD -> VEL -> LIMIT -> WRITE -> (LOAD with index+1 | DONE) -> IDLE.
- IDLE: waits for start; start in any other state is ignored.
- LOAD:
  - which_boid=index.
  - Latch all six read fields (memory read is combinational, same cycle).
- VEL:
  - v = v + acc (32-bit signed, wraps).
  - Integer pixel = pos >>> 16 (arithmetic).
  - If pixel_x < LEFT_MARGIN, vx += TURN; if pixel_x > RIGHT_MARGIN, vx -= TURN. Same rule for y with TOP/BOTTOM.
  - Comparisons are strict and signed.
- LIMIT:
  - If v > MAX_SPEED, v = MAX_SPEED; if v < -MAX_SPEED, v = -MAX_SPEED.
  - pos_new = pos + v_clamped (32-bit signed).
- WRITE:
  - which_boid=index; wb_en=7'h7F for exactly this cycle.
  - Write data: x/y = pos_new, vx/vy = v_clamped, accumulators = 0.
  - wb_en=0 in every other state.
- Cost is 4 cycles per boid. For num_boids=2, done is asserted 9 cycles after the start-accept edge.
- After WRITE:
  - If index==num_boids-1: go to DONE and clear index.
  - Otherwise: index+1, go to LOAD.
- DONE: done=1 for one cycle, busy drops, return to IDLE.
- Write data and which_boid are registered: outputs change only on clk edges.
- Reset mid-operation:
  - Immediate return to IDLE, wb_en=0.
  - Boids already written keep their new values; no partial write occurs.
- A start in the DONE cycle is ignored; a start in the following IDLE cycle is accepted.

Decomposition:
- Package boid_pkg:
  - fix32_t (signed 32-bit Q16.16)
  - FRAC_BITS=16
  - the state enum
  - WB_ALL=7'h7F
  - the margin, TURN and MAX_SPEED defaults
- One sub-module: boid_axis_update (combinational, per axis). Inputs: pos, vel, acc, lo/hi margins. Outputs: next vel and next pos. Instantiated twice (x, y); its result is registered by the FSM stages.

Test Plan:
- Basic update: boid0 x=120<<16, vx=5<<16, vx_acc=1<<16, reset, start -> WRITE writes vx=6<<16, x=126<<16, vx_acc=0, wb_en=7'h7F for 1 cycle; done 9 cycles after start accepted.
- Positive clamp: vx=5<<16, vx_acc=5<<16 -> vx written 6<<16 and x += 6<<16.
- Negative clamp: vy=-4<<16, vy_acc=-10<<16 -> vy=-(6<<16), y decreases by 6<<16.
- Margin turn: x=50<<16, vx=0, acc=0 -> vx=13107, x=(50<<16)+13107. x=541<<16 -> vx=-13107. x exactly 100<<16 -> no turn.
- Busy and back-to-back: start pulsed during busy is ignored (one done only); start in the cycle after DONE begins a new pass.
- Reset mid-pass: assert reset while in VEL of boid1 -> busy=0, wb_en=0 immediately; boid0 holds its updated values, boid1 is unchanged.
